// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external 4-bit ALU among NREQ valid/ready requesters, round-robin by default.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module alu_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_sel,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q;
    logic [IDW-1:0]   last_q, id_q, win_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, a_d, b_d;
    logic [1:0]       sel_q, sel_d;
    logic             carry_q, zero_q, any;

    assign any = |req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        win_d = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[k]) win_d = IDW'(k);
    end
`else
    logic            found;
    logic [NREQ-1:0] rot;
    int              idx;
    // Scan upward from the requester after the last grant, wrapping around.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        rot   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            rot = req_valid >> idx;
            if (!found && rot[0]) begin
                win_d = IDW'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    assign a_d   = WIDTH'(req_a >> (int'(win_d) * WIDTH));
    assign b_d   = WIDTH'(req_b >> (int'(win_d) * WIDTH));
    assign sel_d = 2'(req_sel >> (int'(win_d) * 2));

    // Gated by rst so the accept strobe drops the moment reset asserts.
    assign req_ready  = (state_q == IDLE && !rst && any) ? (NREQ'(1) << win_d) : '0;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = state_q == RESP;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sel_q   <= sel_d;
                    id_q    <= win_d;
                    last_q  <= win_d;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q   <= alu_result;
                    carry_q <= alu_carry;
                    zero_q  <= alu_zero;
                    state_q <= RESP;
                end
                RESP:    if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
